// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - Handshaked instruction-memory loader driving active-low CS/WE/OE strobes.
// Accepts words on a valid/ready stream, writes them at successive addresses, pulses cpu_start when done.
module boot_loader #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned ADDR_STRIDE = 1,
   parameter int unsigned MAX_WORDS   = 1024,
   parameter int unsigned WR_CYCLES   = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   input  logic        in_last,
   output logic        in_ready,
   output logic [31:0] mem_address,
   output logic [31:0] mem_wdata,
   output logic        mem_cs_n,
   output logic        mem_we_n,
   output logic        mem_oe_n,
   output logic [15:0] word_count,
   output logic        boot_done,
   output logic        cpu_start,
   output logic        overflow_err
);

   localparam int unsigned   WCW     = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
   localparam logic [WCW-1:0] WR_LAST = WCW'(WR_CYCLES - 1);
   localparam logic [15:0]    MAX_CNT = 16'(MAX_WORDS);
   localparam logic [31:0]    STRIDE  = 32'(ADDR_STRIDE);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_WORD,
      S_WRITE,
      S_RELEASE,
      S_DONE,
      S_ERROR
   } state_t;

   state_t         state_q, state_d;
   logic [WCW-1:0] wr_cnt_q, wr_cnt_d;
   logic           last_q, last_d;
   logic [31:0]    mem_address_q, mem_address_d;
   logic [31:0]    mem_wdata_q, mem_wdata_d;
   logic           mem_cs_n_q, mem_cs_n_d;
   logic           mem_we_n_q, mem_we_n_d;
   logic           in_ready_q, in_ready_d;
   logic [15:0]    word_count_q, word_count_d;
   logic           boot_done_q, boot_done_d;
   logic           cpu_start_q, cpu_start_d;
   logic           overflow_err_q, overflow_err_d;
   logic           xfer;

   assign xfer = in_valid && in_ready_q;

   // Every registered output is computed from the state being entered, so the
   // strobes and in_ready line up with the state they belong to.
   always_comb begin
      state_d        = state_q;
      wr_cnt_d       = wr_cnt_q;
      last_d         = last_q;
      mem_address_d  = mem_address_q;
      mem_wdata_d    = mem_wdata_q;
      mem_cs_n_d     = 1'b1;
      mem_we_n_d     = 1'b1;
      in_ready_d     = 1'b0;
      word_count_d   = word_count_q;
      boot_done_d    = boot_done_q;
      cpu_start_d    = 1'b0;
      overflow_err_d = overflow_err_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d       = S_WAIT_WORD;
               word_count_d  = 16'd0;
               mem_address_d = BASE_ADDR;
               in_ready_d    = 1'b1;
            end
         end

         S_WAIT_WORD: begin
            in_ready_d = 1'b1;
            if (xfer) begin
               in_ready_d = 1'b0;
               if (word_count_q == MAX_CNT) begin
                  state_d        = S_ERROR;
                  overflow_err_d = 1'b1;
               end else begin
                  state_d     = S_WRITE;
                  mem_wdata_d = in_data;
                  last_d      = in_last;
                  wr_cnt_d    = '0;
                  mem_cs_n_d  = 1'b0;
                  mem_we_n_d  = 1'b0;
               end
            end
         end

         S_WRITE: begin
            if (wr_cnt_q == WR_LAST) begin
               state_d = S_RELEASE;
            end else begin
               wr_cnt_d   = wr_cnt_q + 1'b1;
               mem_cs_n_d = 1'b0;
               mem_we_n_d = 1'b0;
            end
         end

         S_RELEASE: begin
            word_count_d  = word_count_q + 16'd1;
            mem_address_d = mem_address_q + STRIDE;
            if (last_q) begin
               state_d     = S_DONE;
               boot_done_d = 1'b1;
               cpu_start_d = 1'b1;
            end else begin
               state_d    = S_WAIT_WORD;
               in_ready_d = 1'b1;
            end
         end

         S_DONE: begin
            state_d = S_DONE;
         end

         S_ERROR: begin
            state_d = S_ERROR;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= S_IDLE;
         wr_cnt_q       <= '0;
         last_q         <= 1'b0;
         mem_address_q  <= BASE_ADDR;
         mem_wdata_q    <= 32'd0;
         mem_cs_n_q     <= 1'b1;
         mem_we_n_q     <= 1'b1;
         in_ready_q     <= 1'b0;
         word_count_q   <= 16'd0;
         boot_done_q    <= 1'b0;
         cpu_start_q    <= 1'b0;
         overflow_err_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         wr_cnt_q       <= wr_cnt_d;
         last_q         <= last_d;
         mem_address_q  <= mem_address_d;
         mem_wdata_q    <= mem_wdata_d;
         mem_cs_n_q     <= mem_cs_n_d;
         mem_we_n_q     <= mem_we_n_d;
         in_ready_q     <= in_ready_d;
         word_count_q   <= word_count_d;
         boot_done_q    <= boot_done_d;
         cpu_start_q    <= cpu_start_d;
         overflow_err_q <= overflow_err_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign mem_address  = mem_address_q;
   assign mem_wdata    = mem_wdata_q;
   assign mem_cs_n     = mem_cs_n_q;
   assign mem_we_n     = mem_we_n_q;
   assign mem_oe_n     = 1'b1;
   assign word_count   = word_count_q;
   assign boot_done    = boot_done_q;
   assign cpu_start    = cpu_start_q;
   assign overflow_err = overflow_err_q;

endmodule
